// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and PC constants for the fetch sequencer.
package fetch_pkg;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      HALT  = 3'd3
   } state_t;
   localparam logic [31:0] PC_STEP  = 32'd4;
   localparam logic [31:0] RESET_PC = 32'd0;
endpackage

// File: rtl/step_divider.sv
// step_divider: free-running divider producing a 1-cycle tick every TICK_DIV clocks.
module step_divider #(
   parameter int TICK_DIV = 8388608,
   parameter int DIV_W    = 23
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   logic [DIV_W-1:0] div_cnt;
   assign tick = div_cnt == DIV_W'(TICK_DIV - 1);
   always_ff @(posedge clk)
      if (!rst) div_cnt <= '0;
      else div_cnt <= tick ? '0 : div_cnt + 1'b1;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: tick-paced PC sequencer with imem handshake, branch, stall and halt.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int TICK_DIV = 8388608,
   parameter int DIV_W    = 23,
   parameter int OFF_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             halt_req,
   input  logic             stall,
   input  logic             branch_req,
   input  logic [OFF_W-1:0] branch_offset,
   input  logic             imem_ack,
   output logic             imem_req,
   output logic [31:0]      pc,
   output logic             pc_valid,
   output logic             tick,
   output logic [2:0]       state,
   output logic             halted
);
   state_t cur, nxt;
   logic branch_pending, update;
   logic [OFF_W-1:0] off_q, off_sel;
   logic [31:0] pc_next;
   step_divider #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) u_div (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );
   assign update  = cur == EXEC && tick && !stall && !halt_req;
   // a branch_req on the update cycle itself supplies its own offset
   assign off_sel = branch_req ? branch_offset : off_q;
   assign pc_next = pc + PC_STEP + ((branch_req || branch_pending) ?
                    {{(32-OFF_W){off_sel[OFF_W-1]}}, off_sel} : 32'd0);
   always_ff @(posedge clk)
      if (!rst) cur <= IDLE;
      else cur <= nxt;
   always_ff @(posedge clk)
      if (!rst) begin
         pc             <= RESET_PC;
         branch_pending <= 1'b0;
         off_q          <= '0;
      end else begin
         if (update) pc <= pc_next;
         branch_pending <= (cur == EXEC && !update && !halt_req) ? (branch_pending || branch_req) : 1'b0;
         off_q          <= (cur == EXEC && branch_req) ? branch_offset : off_q;
      end
   always_comb begin
      nxt = cur;
      case (cur)
         IDLE:    nxt = halt_req ? HALT : run ? FETCH : IDLE;
         FETCH:   nxt = halt_req ? HALT : imem_ack ? EXEC : FETCH;
         EXEC:    nxt = halt_req ? HALT : update ? (run ? FETCH : IDLE) : EXEC;
         HALT:    nxt = HALT;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      imem_req = cur == FETCH;
      pc_valid = cur == FETCH && imem_ack && !halt_req;
      halted   = cur == HALT;
      state    = cur;
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench with a pc scoreboard checked on every pc_valid.
module tb_fetch_sequencer;
   logic clk = 1'b0, rst = 1'b0, run = 1'b0, halt_req = 1'b0, stall = 1'b0;
   logic branch_req = 1'b0, imem_ack = 1'b0;
   logic [15:0] branch_offset = '0;
   logic imem_req, pc_valid, tick, halted;
   logic [31:0] pc;
   logic [2:0] state;
   int vectors = 0, miscompares = 0, gap = 0;
   bit seen = 1'b0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   fetch_sequencer #(.TICK_DIV(4), .DIV_W(2), .OFF_W(16)) dut (
      .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .stall(stall),
      .branch_req(branch_req), .branch_offset(branch_offset), .imem_ack(imem_ack),
      .imem_req(imem_req), .pc(pc), .pc_valid(pc_valid), .tick(tick),
      .state(state), .halted(halted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20 && !imem_req; i++) cyc();
      chk("req_timeout", {31'b0, imem_req}, 32'd1);
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 20 && !tick; i++) cyc();
      chk("tick_timeout", {31'b0, tick}, 32'd1);
   endtask

   task automatic do_fetch(input logic [31:0] p);
      wait_req();
      chk("fetch_pc", pc, p);
      sb.push_back(p);
      imem_ack = 1'b1;
      #1;
      chk("pc_valid", {31'b0, pc_valid}, 32'd1);
      cyc();
      imem_ack = 1'b0;
      chk("exec_state", {29'b0, state}, 32'd2);
   endtask

   task automatic step(input logic [31:0] exp, input string tag);
      wait_tick();
      cyc();
      chk(tag, pc, exp);
   endtask

   always @(posedge clk)
      if (pc_valid) begin
         if (sb.size() == 0) chk("sb_extra_valid", {31'b0, pc_valid}, 32'd0);
         else chk("sb_pc", pc, sb.pop_front());
      end

   always @(negedge clk)
      if (!rst) seen = 1'b0;
      else begin
         gap++;
         if (tick) begin
            if (seen) chk("tick_period", 32'(gap), 32'd4);
            seen = 1'b1;
            gap = 0;
         end
      end

   initial begin
      #100000;
      $fatal(1, "FAIL global_timeout observed=running expected=finished");
   end

   initial begin
      repeat (3) cyc();
      chk("rst_pc", pc, 32'd0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_state", {29'b0, state}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      chk("rst_tick", {31'b0, tick}, 32'd0);
      chk("rst_valid", {31'b0, pc_valid}, 32'd0);
      rst = 1'b1;
      run = 1'b1;
      cyc();
      chk("req_after_release", {31'b0, imem_req}, 32'd1);
      chk("state_fetch", {29'b0, state}, 32'd1);
      branch_req = 1'b1;
      branch_offset = 16'h0100;
      cyc();
      cyc();
      branch_req = 1'b0;
      chk("req_held", {31'b0, imem_req}, 32'd1);
      do_fetch(32'd0);
      step(32'd4, "seq_pc4_fetch_branch_ignored");
      chk("req_with_new_pc", {31'b0, imem_req}, 32'd1);
      do_fetch(32'd4);
      step(32'd8, "seq_pc8");
      do_fetch(32'd8);
      step(32'd12, "seq_pc12");
      do_fetch(32'd12);
      step(32'd16, "seq_pc16");
      do_fetch(32'd16);
      branch_req = 1'b1;
      branch_offset = 16'h0100;
      cyc();
      branch_offset = 16'hFFF8;
      cyc();
      branch_req = 1'b0;
      chk("br_no_early_change", pc, 32'd16);
      step(32'd12, "br_overwrite_neg");
      do_fetch(32'd12);
      wait_tick();
      branch_req = 1'b1;
      branch_offset = 16'h0010;
      cyc();
      branch_req = 1'b0;
      chk("br_same_tick", pc, 32'd32);
      do_fetch(32'd32);
      branch_req = 1'b1;
      branch_offset = 16'h0020;
      stall = 1'b1;
      cyc();
      branch_req = 1'b0;
      step(32'd32, "stall_tick1");
      chk("stall_state", {29'b0, state}, 32'd2);
      step(32'd32, "stall_tick2");
      stall = 1'b0;
      step(32'd68, "stall_release_branch");
      do_fetch(32'd68);
      run = 1'b0;
      step(32'd72, "run0_pc");
      chk("run0_idle", {29'b0, state}, 32'd0);
      chk("run0_no_req", {31'b0, imem_req}, 32'd0);
      run = 1'b1;
      do_fetch(32'd72);
      branch_req = 1'b1;
      branch_offset = 16'h0040;
      cyc();
      branch_req = 1'b0;
      wait_tick();
      halt_req = 1'b1;
      cyc();
      halt_req = 1'b0;
      chk("halt_state", {29'b0, state}, 32'd3);
      chk("halt_flag", {31'b0, halted}, 32'd1);
      chk("halt_pc", pc, 32'd72);
      chk("halt_no_req", {31'b0, imem_req}, 32'd0);
      imem_ack = 1'b1;
      #1;
      chk("halt_ack_ignored", {31'b0, pc_valid}, 32'd0);
      cyc();
      imem_ack = 1'b0;
      repeat (4) cyc();
      chk("halt_pc_frozen", pc, 32'd72);
      chk("halt_sticky", {29'b0, state}, 32'd3);
      rst = 1'b0;
      cyc();
      chk("halt_rst_state", {29'b0, state}, 32'd0);
      chk("halt_rst_pc", pc, 32'd0);
      chk("halt_rst_flag", {31'b0, halted}, 32'd0);
      rst = 1'b1;
      cyc();
      do_fetch(32'd0);
      branch_req = 1'b1;
      branch_offset = 16'hFFF8;
      cyc();
      branch_req = 1'b0;
      step(32'hFFFF_FFFC, "wrap_pre");
      do_fetch(32'hFFFF_FFFC);
      step(32'd0, "wrap_zero");
      do_fetch(32'd0);
      step(32'd4, "pre_rst_pc");
      rst = 1'b0;
      cyc();
      chk("midfetch_rst_pc", pc, 32'd0);
      chk("midfetch_rst_state", {29'b0, state}, 32'd0);
      chk("midfetch_rst_req", {31'b0, imem_req}, 32'd0);
      imem_ack = 1'b1;
      #1;
      chk("late_ack_ignored", {31'b0, pc_valid}, 32'd0);
      rst = 1'b1;
      run = 1'b0;
      cyc();
      chk("idle_after_rst", {29'b0, state}, 32'd0);
      imem_ack = 1'b0;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
